// File: rtl/sparse_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter slice.
package sparse_arb_pkg;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry register FIFO holding read responses until the consumer takes them.
module sram_rsp_fifo
    import sparse_arb_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DATA_W-1:0]    push_data_i,
    input  logic                 pop_i,
    output logic [DATA_W-1:0]    head_data_o,
    output logic [RSP_CNT_W-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DATA_W-1:0]    mem_q [RSP_DEPTH];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [RSP_CNT_W-1:0] count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o      = (count_q == RSP_CNT_W'(RSP_DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;

    // Storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + RSP_CNT_W'(do_push) - RSP_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates a write path and a credit-limited read path onto one single-port SRAM.
module sram_port_arbiter
    import sparse_arb_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en_i,
    input  logic              flush_i,
    input  logic              rr_mode_i,
    input  logic              prio_rd_i,
    input  logic              wr_req_valid_i,
    output logic              wr_req_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_rsp_data_o,
    output logic              rd_rsp_valid_o,
    input  logic              rd_rsp_ready_i,
    output logic [ADDR_W-1:0] addr_to_mem_o,
    output logic [DATA_W-1:0] data_to_mem_o,
    output logic              wen_to_mem_o,
    output logic              ren_to_mem_o,
    input  logic [DATA_W-1:0] data_from_mem_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                 inflight_q, inflight_d;
    grant_e               last_grant_q, last_grant_d;
    grant_e               starve_side_q, starve_side_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;

    logic [RSP_CNT_W-1:0] fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clear;

    logic                 active;
    logic                 wr_elig;
    logic                 rd_elig;
    logic                 contend;
    logic                 forced;
    logic                 any_gnt;
    logic                 wr_gnt;
    logic                 rd_gnt;
    grant_e               winner;
    logic [RSP_CNT_W:0]   credit_used;

    assign active      = clk_en_i & ~flush_i;
    // Credit uses the pre-pop count, so a same-cycle pop never frees a slot early.
    assign credit_used = {1'b0, fifo_count} + (RSP_CNT_W + 1)'(inflight_q);
    assign rd_elig     = rd_req_valid_i & (credit_used < (RSP_CNT_W + 1)'(RSP_DEPTH));
    assign wr_elig     = wr_req_valid_i;
    assign contend     = wr_elig & rd_elig;
    assign forced      = contend & ~rr_mode_i & (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        winner        = GNT_WR;
        starve_cnt_d  = '0;
        starve_side_d = starve_side_q;
        if (contend) begin
            if (rr_mode_i) begin
                winner = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
            end else if (forced) begin
                winner = starve_side_q;
            end else begin
                winner = prio_rd_i ? GNT_RD : GNT_WR;
            end
        end else if (rd_elig) begin
            winner = GNT_RD;
        end

        if (contend && !rr_mode_i && !forced) begin
            starve_cnt_d  = (starve_cnt_q == CNT_W'(STARVE_MAX)) ? starve_cnt_q
                                                                 : starve_cnt_q + CNT_W'(1);
            starve_side_d = (winner == GNT_WR) ? GNT_RD : GNT_WR;
        end
    end

    assign any_gnt      = (wr_elig | rd_elig) & active;
    assign wr_gnt       = any_gnt & (winner == GNT_WR);
    assign rd_gnt       = any_gnt & (winner == GNT_RD);
    assign last_grant_d = any_gnt ? winner : last_grant_q;
    assign inflight_d   = rd_gnt;

    assign wr_req_ready_o = wr_gnt;
    assign rd_req_ready_o = rd_gnt;
    assign wen_to_mem_o   = wr_gnt;
    assign ren_to_mem_o   = rd_gnt;
    assign addr_to_mem_o  = rd_gnt ? rd_addr_i : wr_addr_i;
    assign data_to_mem_o  = wr_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            last_grant_q  <= GNT_WR;
            starve_cnt_q  <= '0;
            starve_side_q <= GNT_WR;
        end else if (clk_en_i) begin
            if (flush_i) begin
                inflight_q    <= 1'b0;
                last_grant_q  <= GNT_WR;
                starve_cnt_q  <= '0;
                starve_side_q <= GNT_WR;
            end else begin
                inflight_q    <= inflight_d;
                last_grant_q  <= last_grant_d;
                starve_cnt_q  <= starve_cnt_d;
                starve_side_q <= starve_side_d;
            end
        end
    end

    // A flush drops the in-flight read: its data arrives but is never pushed.
    assign fifo_push  = active & inflight_q;
    assign fifo_pop   = active & rd_rsp_valid_o & rd_rsp_ready_i;
    assign fifo_clear = clk_en_i & flush_i;

    sram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (fifo_clear),
        .push_i      (fifo_push),
        .push_data_i (data_from_mem_i),
        .pop_i       (fifo_pop),
        .head_data_o (rd_rsp_data_o),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rd_rsp_valid_o = ~fifo_empty;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                          !(fifo_push && fifo_full));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random checks of sram_port_arbiter against a queue-based reference model.
module tb_sram_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clkEn, flush, rrMode, prioRd;
    logic        wrValid, wrReady, rdValid, rdReady;
    logic [8:0]  wrAddr, rdAddr, addrToMem;
    logic [63:0] wrData, rspData, dataToMem, dataFromMem;
    logic        rspValid, rspRdy, wenToMem, renToMem;

    logic [63:0] sramArr [512];
    logic [63:0] memModel [512];
    logic [63:0] rspQ [$];
    int          mLast, mCnt, mSide, mInfl;
    logic [63:0] mInflData;

    int          numChecks = 0;
    int          numFails  = 0;
    int          obsGnt;
    logic        obsValid, obsRen;
    logic [63:0] obsData;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk             (clk),
        .rst_n           (rstN),
        .clk_en_i        (clkEn),
        .flush_i         (flush),
        .rr_mode_i       (rrMode),
        .prio_rd_i       (prioRd),
        .wr_req_valid_i  (wrValid),
        .wr_req_ready_o  (wrReady),
        .wr_addr_i       (wrAddr),
        .wr_data_i       (wrData),
        .rd_req_valid_i  (rdValid),
        .rd_req_ready_o  (rdReady),
        .rd_addr_i       (rdAddr),
        .rd_rsp_data_o   (rspData),
        .rd_rsp_valid_o  (rspValid),
        .rd_rsp_ready_i  (rspRdy),
        .addr_to_mem_o   (addrToMem),
        .data_to_mem_o   (dataToMem),
        .wen_to_mem_o    (wenToMem),
        .ren_to_mem_o    (renToMem),
        .data_from_mem_i (dataFromMem)
    );

    function automatic logic [63:0] preloadVal(int a);
        if (a == 5) return 64'hDEAD;
        return {32'hC0DE_0000 | 32'(a), 32'(a * 3 + 1)};
    endfunction

    // Behavioural single-port SRAM sharing the global clock enable.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 512; i++) sramArr[i] <= preloadVal(i);
            dataFromMem <= '0;
        end else if (clkEn) begin
            if (wenToMem) sramArr[addrToMem] <= dataToMem;
            if (renToMem) dataFromMem <= sramArr[addrToMem];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [8:0] wa, input logic [63:0] wd,
                                 input logic rv, input logic [8:0] ra);
        wrValid = wv;
        wrAddr  = wa;
        wrData  = wd;
        rdValid = rv;
        rdAddr  = ra;
    endtask

    task automatic resetModel();
        rspQ.delete();
        mInfl = 0;
        mLast = 0;
        mCnt  = 0;
        mSide = 0;
    endtask

    // Predict this cycle's grant from the arbitration rules, compare, then advance the model.
    task automatic runCycle();
        int  win;
        bit  rdE, wrE, forced, act;
        @(negedge clk);
        rdE    = rdValid && (rspQ.size() + mInfl < 2);
        wrE    = wrValid;
        act    = clkEn && !flush;
        forced = 0;
        win    = -1;
        if (act && (rdE || wrE)) begin
            if (rdE && wrE) begin
                if (rrMode) win = 1 - mLast;
                else if (mCnt == STARVE) begin
                    win    = mSide;
                    forced = 1;
                end else win = prioRd ? 1 : 0;
            end else win = rdE ? 1 : 0;
        end
        checkOutput("wrReady", 64'(wrReady), 64'(win == 0));
        checkOutput("rdReady", 64'(rdReady), 64'(win == 1));
        checkOutput("wen", 64'(wenToMem), 64'(win == 0));
        checkOutput("ren", 64'(renToMem), 64'(win == 1));
        if (win >= 0) checkOutput("addrToMem", 64'(addrToMem), 64'(win == 1 ? rdAddr : wrAddr));
        checkOutput("dataToMem", dataToMem, wrData);
        checkOutput("rspValid", 64'(rspValid), 64'(rspQ.size() != 0));
        if (rspQ.size() != 0) checkOutput("rspData", rspData, rspQ[0]);
        obsGnt   = wrReady ? 0 : (rdReady ? 1 : -1);
        obsValid = rspValid;
        obsData  = rspData;
        obsRen   = renToMem;
        @(posedge clk);
        if (clkEn) begin
            if (flush) resetModel();
            else begin
                if (rspQ.size() != 0 && rspRdy) void'(rspQ.pop_front());
                if (mInfl != 0) rspQ.push_back(mInflData);
                mInfl = (win == 1) ? 1 : 0;
                if (win == 1) mInflData = memModel[rdAddr];
                if (win == 0) memModel[wrAddr] = wrData;
                if (win >= 0) mLast = win;
                if (rdE && wrE && !rrMode) begin
                    if (forced) mCnt = 0;
                    else begin
                        mCnt  = (mCnt + 1 > STARVE) ? STARVE : mCnt + 1;
                        mSide = 1 - win;
                    end
                end else mCnt = 0;
            end
        end
        #1;
    endtask

    task automatic flushCycle();
        applyStimulus(0, '0, '0, 0, '0);
        flush = 1;
        runCycle();
        flush = 0;
    endtask

    initial begin
        int exp2 [6]  = '{1, 0, 1, 0, 1, 0};
        int exp3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int nRd;

        rstN   = 0;
        clkEn  = 1;
        flush  = 0;
        rrMode = 0;
        prioRd = 0;
        rspRdy = 1;
        applyStimulus(0, '0, '0, 0, '0);
        for (int i = 0; i < 512; i++) memModel[i] = preloadVal(i);
        resetModel();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetRspValid", 64'(rspValid), 64'd0);
        checkOutput("resetWrReady", 64'(wrReady), 64'd0);
        checkOutput("resetRdReady", 64'(rdReady), 64'd0);
        checkOutput("resetWen", 64'(wenToMem), 64'd0);
        checkOutput("resetRen", 64'(renToMem), 64'd0);
        @(posedge clk);
        #1 rstN = 1;

        // Single read with two-cycle response latency.
        applyStimulus(0, '0, '0, 1, 9'd5);
        runCycle();
        checkOutput("t1RenAtT", 64'(obsRen), 64'd1);
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        checkOutput("t1NoRspAtT1", 64'(obsValid), 64'd0);
        runCycle();
        checkOutput("t1RspValid", 64'(obsValid), 64'd1);
        checkOutput("t1RspData", obsData, 64'hDEAD);
        runCycle();

        // Round robin alternation starting from the read side.
        flushCycle();
        rrMode = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 9'(40 + i), 64'(i), 1, 9'(60 + i));
            runCycle();
            checkOutput("t2RrGrant", 64'(obsGnt), 64'(exp2[i]));
        end

        // Fixed write priority with the starvation guard.
        flushCycle();
        rrMode = 0;
        prioRd = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 9'(70 + i), 64'(100 + i), 1, 9'(90 + i));
            runCycle();
            checkOutput("t3FixedGrant", 64'(obsGnt), 64'(exp3[i]));
        end

        // Credit limit under response backpressure.
        flushCycle();
        rspRdy = 0;
        nRd    = 0;
        applyStimulus(0, '0, '0, 1, 9'd11);
        for (int i = 0; i < 6; i++) begin
            runCycle();
            if (obsGnt == 1) nRd++;
        end
        checkOutput("t4ReadsIssued", 64'(nRd), 64'd2);
        rspRdy = 1;
        runCycle();
        checkOutput("t4NoGrantOnPop", 64'(obsGnt), 64'(-1));
        rspRdy = 0;
        runCycle();
        checkOutput("t4GrantAfterPop", 64'(obsGnt), 64'd1);
        rspRdy = 1;
        applyStimulus(0, '0, '0, 0, '0);
        repeat (4) runCycle();

        // Write followed by read of the same address.
        applyStimulus(1, 9'd9, 64'h1234, 0, '0);
        runCycle();
        applyStimulus(0, '0, '0, 1, 9'd9);
        runCycle();
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        runCycle();
        checkOutput("t5RspValid", 64'(obsValid), 64'd1);
        checkOutput("t5RspData", obsData, 64'h1234);

        // Flush discards an in-flight read.
        flushCycle();
        applyStimulus(0, '0, '0, 1, 9'd5);
        runCycle();
        flushCycle();
        for (int i = 0; i < 4; i++) begin
            runCycle();
            checkOutput("t6NoRspAfterFlush", 64'(obsValid), 64'd0);
        end

        // Clock enable low freezes an in-flight read.
        applyStimulus(0, '0, '0, 1, 9'd7);
        runCycle();
        clkEn = 0;
        applyStimulus(1, 9'd30, 64'h55, 1, 9'd31);
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("t6GatedNoAccess", 64'(obsGnt), 64'(-1));
        end
        clkEn = 1;
        applyStimulus(0, '0, '0, 0, '0);
        runCycle();
        checkOutput("t6NoRspYet", 64'(obsValid), 64'd0);
        runCycle();
        checkOutput("t6RspValid", 64'(obsValid), 64'd1);
        checkOutput("t6RspData", obsData, preloadVal(7));
        runCycle();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            clkEn  = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            rspRdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) rrMode = ~rrMode;
            if ($urandom_range(0, 49) == 0) prioRd = ~prioRd;
            applyStimulus(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                          {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)));
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
